// File: rtl/timer_mode_controller_pkg.sv
// Shared types and helpers for the two-mode MM:SS timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t m1;
        bcd_digit_t m0;
        bcd_digit_t s1;
        bcd_digit_t s0;
    } mmss_t;

    localparam int unsigned BCD_W   = 16;
    localparam int unsigned ALARM_W = 8;

    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_COUNTDOWN = 1'b1;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_digit_t TENS_MAX  = 4'd5;

    // Minute ceiling as two BCD digits {M1,M0}.
    function automatic logic [7:0] min_to_bcd(input int unsigned m);
        return {bcd_digit_t'(m / 10), bcd_digit_t'(m % 10)};
    endfunction

    // Clamp every digit into its legal range, then clamp minutes to the ceiling.
    function automatic mmss_t sanitize_preset(input mmss_t p, input logic [7:0] max_min);
        mmss_t r;
        r.m1 = (p.m1 > DIGIT_MAX) ? DIGIT_MAX : p.m1;
        r.m0 = (p.m0 > DIGIT_MAX) ? DIGIT_MAX : p.m0;
        r.s1 = (p.s1 > TENS_MAX)  ? TENS_MAX  : p.s1;
        r.s0 = (p.s0 > DIGIT_MAX) ? DIGIT_MAX : p.s0;
        if ({r.m1, r.m0} > max_min) begin
            r.m1 = max_min[7:4];
            r.m0 = max_min[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_mode_controller_if.sv
// Button-pulse / display bus between conditioning stage, controller and display.
interface timer_mode_controller_if;
    logic               tick;
    logic               ss_pulse;
    logic               mode_pulse;
    logic               clear_pulse;
    timer_pkg::mmss_t   preset_bcd;
    timer_pkg::mmss_t   count_bcd;
    logic               running;
    logic               mode;
    logic               alarm;

    modport master (
        output tick, ss_pulse, mode_pulse, clear_pulse, preset_bcd,
        input  count_bcd, running, mode, alarm
    );

    modport slave (
        input  tick, ss_pulse, mode_pulse, clear_pulse, preset_bcd,
        output count_bcd, running, mode, alarm
    );
endinterface

// File: rtl/timer_mode_controller_bcd_mmss_counter.sv
// MM:SS BCD up/down counter with load; saturates at 00:00 and at MAX_MINUTES:59.
module bcd_mmss_counter
    import timer_pkg::*;
#(
    parameter int unsigned MAX_MINUTES = 59
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  mmss_t load_val,
    input  logic  inc,
    input  logic  dec,
    output mmss_t count,
    output logic  at_zero,
    output logic  at_max
);

    localparam logic [7:0] MAX_MIN_BCD = min_to_bcd(MAX_MINUTES);
    localparam mmss_t      MAX_VAL     = {MAX_MIN_BCD, TENS_MAX, DIGIT_MAX};

    mmss_t w_inc_val;
    mmss_t w_dec_val;
    mmss_t w_next;

    // Per-digit increment with carry.
    always_comb begin
        w_inc_val = count;
        if (count.s0 != DIGIT_MAX) begin
            w_inc_val.s0 = count.s0 + 4'd1;
        end else begin
            w_inc_val.s0 = 4'd0;
            if (count.s1 != TENS_MAX) begin
                w_inc_val.s1 = count.s1 + 4'd1;
            end else begin
                w_inc_val.s1 = 4'd0;
                if (count.m0 != DIGIT_MAX) begin
                    w_inc_val.m0 = count.m0 + 4'd1;
                end else begin
                    w_inc_val.m0 = 4'd0;
                    w_inc_val.m1 = count.m1 + 4'd1;
                end
            end
        end
    end

    // Per-digit decrement with borrow.
    always_comb begin
        w_dec_val = count;
        if (count.s0 != 4'd0) begin
            w_dec_val.s0 = count.s0 - 4'd1;
        end else begin
            w_dec_val.s0 = DIGIT_MAX;
            if (count.s1 != 4'd0) begin
                w_dec_val.s1 = count.s1 - 4'd1;
            end else begin
                w_dec_val.s1 = TENS_MAX;
                if (count.m0 != 4'd0) begin
                    w_dec_val.m0 = count.m0 - 4'd1;
                end else begin
                    w_dec_val.m0 = DIGIT_MAX;
                    w_dec_val.m1 = count.m1 - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_next = count;
        if (load) begin
            w_next = load_val;
        end else if (inc && !at_max) begin
            w_next = w_inc_val;
        end else if (dec && !at_zero) begin
            w_next = w_dec_val;
        end
    end

    // Flags are registered from the next value so they line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            at_zero <= 1'b1;
            at_max  <= 1'b0;
        end else begin
            count   <= w_next;
            at_zero <= (w_next == mmss_t'(0));
            at_max  <= (w_next == MAX_VAL);
        end
    end

endmodule

// File: rtl/timer_mode_controller.sv
// Stopwatch / countdown sequencing FSM owning the MM:SS count.
// Optional alarm auto-return timer enabled by defining TIMER_ALARM_TIMEOUT_EN.
module timer_mode_controller
    import timer_pkg::*;
#(
    parameter int unsigned MAX_MINUTES = 59,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    timer_mode_controller_if.slave  bus
);

    localparam logic [7:0] MAX_MIN_BCD = min_to_bcd(MAX_MINUTES);
    localparam mmss_t      COUNT_ONE   = mmss_t'(16'h0001);

    if (MAX_MINUTES < 1 || MAX_MINUTES > 99 || ALARM_TICKS < 1 || ALARM_TICKS > 255) begin : g_bad_params
        $error("timer_mode_controller: parameter out of range");
    end

    state_t r_state;
    state_t w_next_state;
    logic   r_mode;
    logic   w_next_mode;
    logic   r_running;
    logic   r_alarm;
    logic   w_load;
    logic   w_inc;
    logic   w_dec;
    logic   w_expire;
    logic   w_timeout;
    mmss_t  w_load_val;
    mmss_t  w_count;
    logic   w_at_zero;
    logic   w_at_max;

`ifdef TIMER_ALARM_TIMEOUT_EN
    localparam logic [ALARM_W-1:0] ALARM_LOAD = ALARM_W'(ALARM_TICKS);

    logic [ALARM_W-1:0] r_alarm_cnt;

    // Loaded on entry to EXPIRED, counts ticks down while there, cleared elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm_cnt <= '0;
        end else if (w_next_state != EXPIRED) begin
            r_alarm_cnt <= '0;
        end else if (r_state != EXPIRED) begin
            r_alarm_cnt <= ALARM_LOAD;
        end else if (bus.tick) begin
            r_alarm_cnt <= r_alarm_cnt - ALARM_W'(1);
        end
    end

    assign w_timeout = bus.tick && (r_alarm_cnt <= ALARM_W'(1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= MODE_STOPWATCH;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_mode    <= w_next_mode;
            r_running <= (w_next_state == RUN);
            r_alarm   <= (w_next_state == EXPIRED);
        end
    end

    // Next state and counter controls; clear > ss > mode in every state.
    always_comb begin
        w_next_state = r_state;
        w_next_mode  = r_mode;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_expire     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.clear_pulse) begin
                    w_load = 1'b1;
                end else if (bus.ss_pulse) begin
                    w_next_state = (r_mode == MODE_COUNTDOWN && w_at_zero) ? EXPIRED : RUN;
                end else if (bus.mode_pulse) begin
                    w_next_mode = ~r_mode;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (bus.clear_pulse) begin
                    w_next_state = IDLE;
                    w_load       = 1'b1;
                end else begin
                    if (bus.tick) begin
                        if (r_mode == MODE_STOPWATCH) begin
                            w_expire = w_at_max;
                            w_inc    = ~w_at_max;
                        end else begin
                            w_expire = w_at_zero || (w_count == COUNT_ONE);
                            w_dec    = ~w_at_zero;
                        end
                    end
                    // Reaching the boundary wins over a coincident pause.
                    if (w_expire) begin
                        w_next_state = EXPIRED;
                    end else if (bus.ss_pulse) begin
                        w_next_state = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (bus.clear_pulse) begin
                    w_next_state = IDLE;
                    w_load       = 1'b1;
                end else if (bus.ss_pulse) begin
                    w_next_state = RUN;
                end
            end
            EXPIRED: begin
                if (bus.clear_pulse || bus.ss_pulse || w_timeout) begin
                    w_next_state = IDLE;
                    w_load       = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_load_val = (w_next_mode == MODE_COUNTDOWN)
                      ? sanitize_preset(bus.preset_bcd, MAX_MIN_BCD)
                      : mmss_t'(0);

    bcd_mmss_counter #(
        .MAX_MINUTES (MAX_MINUTES)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .inc      (w_inc),
        .dec      (w_dec),
        .count    (w_count),
        .at_zero  (w_at_zero),
        .at_max   (w_at_max)
    );

    assign bus.count_bcd = w_count;
    assign bus.running   = r_running;
    assign bus.mode      = r_mode;
    assign bus.alarm     = r_alarm;

endmodule
